memory_rw: RTL
==============

MEMORY_RW -- requirements
Module: memory_rw

Interface
REQ-001 Parameter SIZE, default 256, memory depth in bytes (power of two, 4..65536).
REQ-002 Parameter ADDRESS_WIDTH, default 8, byte-address width; SHALL satisfy 2^ADDRESS_WIDTH >= SIZE.
REQ-003 Parameter DELAY_MODE, default 1, latency mode: 0 = none, 1 = address-dependent, 2 = fixed.
REQ-004 Parameter FIXED_DELAY, default 3, wait cycles used in DELAY_MODE 2, range 0..15.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request strobe, sampled only while ready=1.
REQ-008 write  input  1  1 = write, 0 = read, sampled with start.
REQ-009 size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 address  input  ADDRESS_WIDTH  byte address of the most significant byte.
REQ-011 data_in  input  32  write data, right-aligned, sampled with start.
REQ-012 data_out  output  32  read data, right-aligned, zero-extended.
REQ-013 ready  output  1  1 = idle and able to accept start.
REQ-014 error  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-015 The block SHALL use three states: IDLE (ready=1), WAIT, ACCESS.
REQ-016 IDLE with start=1 and size!=11: latch write, size, address, data_in; load the delay counter; go to WAIT.
REQ-017 IDLE with start=1 and size=11: stay IDLE, assert error for exactly one cycle, leave memory and data_out unchanged.
REQ-018 Delay D: mode 0 gives 0; mode 1 gives address[1:0]; mode 2 gives FIXED_DELAY.
REQ-019 WAIT SHALL decrement the counter each cycle; at 0 it SHALL go to ACCESS.
REQ-020 ACCESS SHALL perform the transfer and return to IDLE on the same edge, so ready is low for exactly D+2 cycles.
REQ-021 start while ready=0 SHALL be ignored; latched request fields SHALL NOT change.
REQ-022 Byte order SHALL be big-endian: byte at address A is the most significant byte of the access, byte A+n+1 follows.
REQ-023 Byte address arithmetic SHALL wrap modulo SIZE, so a word at SIZE-2 uses bytes SIZE-2, SIZE-1, 0, 1.
REQ-024 Read: data_out SHALL update on the ACCESS edge and be valid when ready rises; unused upper bytes are 0.
REQ-025 Write: all 1/2/4 bytes SHALL be written on the ACCESS edge from the low bytes of the latched data_in; data_out is unchanged.
REQ-026 data_out SHALL hold its value until the next read completes.
REQ-027 No alignment restriction SHALL apply; unaligned accesses complete normally.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, ready=1, error=0, data_out=0, delay counter=0.
REQ-029 Reset SHALL initialise memory to bytes 0:8'h59, 1:8'h5c, 2:8'h57 and all remaining bytes (3..SIZE-1) to 0.
REQ-030 Reset asserted during WAIT or ACCESS SHALL abort the request; no write is performed.

Verification
REQ-031 Default params, after reset, read size=00 addr=1 -> ready low 3 cycles (D=1), data_out=32'h0000005c.
REQ-032 Read size=10 addr=0 -> data_out=32'h595c5700, ready low 2 cycles.
REQ-033 Write size=10 addr=8'hfe data_in=32'hdeadbeef, then byte reads 8'hfe, 8'hff, 0x00, 0x01 -> de, ad, be, ef (wraps, overwriting 59 and 5c).
REQ-034 start size=11 -> error high exactly 1 cycle, ready stays 1, data_out unchanged.
REQ-035 Start a write addr=4 in DELAY_MODE 2, FIXED_DELAY=3, pull reset low during WAIT -> ready=1 at once, then read addr=4 returns 0.
REQ-036 start pulsed during a busy read -> second request ignored; exactly one completion seen with the first address's data.

Source files
------------

// File: rtl/memory_rw.sv
// Byte-addressed big-endian memory with byte/halfword/word access and a configurable
// per-request wait latency, sequenced by an IDLE/WAIT/ACCESS state machine.
module memory_rw #(
    parameter int unsigned SIZE          = 256,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DELAY_MODE    = 1,
    parameter int unsigned FIXED_DELAY   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     write,
    input  logic [1:0]               size,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [31:0]              data_in,
    output logic [31:0]              data_out,
    output logic                     ready,
    output logic                     error
);

    localparam int unsigned IdxW = $clog2(SIZE);

    typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     write_q, write_d;
    logic [1:0]               size_q, size_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              data_out_q, data_out_d;
    logic                     error_q, error_d;

    logic [7:0]      mem_q [SIZE];
    logic [IdxW-1:0] idx [4];
    logic [3:0]      lane_en;
    logic [3:0]      mem_we;
    logic [7:0]      wbyte [4];
    logic [31:0]     rdata;
    logic [3:0]      delay;

    always_comb begin
        if (DELAY_MODE == 0) begin
            delay = 4'd0;
        end else if (DELAY_MODE == 1) begin
            delay = {2'b00, address[1:0]};
        end else begin
            delay = 4'(FIXED_DELAY);
        end
    end

    // Index truncation to IdxW bits gives the modulo-SIZE wrap for free.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = addr_q[IdxW-1:0] + IdxW'(k);
        end
    end

    always_comb begin
        rdata   = 32'h0;
        lane_en = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wbyte[k] = 8'h00;
        end
        unique case (size_q)
            2'b00: begin
                rdata    = {24'h0, mem_q[idx[0]]};
                lane_en  = 4'b0001;
                wbyte[0] = wdata_q[7:0];
            end
            2'b01: begin
                rdata    = {16'h0, mem_q[idx[0]], mem_q[idx[1]]};
                lane_en  = 4'b0011;
                wbyte[0] = wdata_q[15:8];
                wbyte[1] = wdata_q[7:0];
            end
            default: begin
                rdata   = {mem_q[idx[0]], mem_q[idx[1]], mem_q[idx[2]], mem_q[idx[3]]};
                lane_en = 4'b1111;
                for (int k = 0; k < 4; k++) begin
                    wbyte[k] = wdata_q[8*(3-k) +: 8];
                end
            end
        endcase
        mem_we = (state_q == StAccess && write_q) ? lane_en : 4'b0000;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        error_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (size == 2'b11) begin
                        error_d = 1'b1;
                    end else begin
                        write_d = write;
                        size_d  = size;
                        addr_d  = address;
                        wdata_d = data_in;
                        cnt_d   = delay;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                if (!write_q) begin
                    data_out_d = rdata;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            data_out_q <= 32'h0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: 8'h00};
            mem_q[0] <= 8'h59;
            mem_q[1] <= 8'h5c;
            mem_q[2] <= 8'h57;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (mem_we[k]) begin
                    mem_q[idx[k]] <= wbyte[k];
                end
            end
        end
    end

    assign ready    = (state_q == StIdle);
    assign error    = error_q;
    assign data_out = data_out_q;

endmodule
